// File: rtl/mem_bist_ctrl.sv
// March C- BIST controller and Avalon-MM access multiplexer for one single-port data memory.
// Optional build macro MBIST_DIAG_EN: run every element to completion and expose err_count.
module mem_bist_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                bist_start,
  output logic                bist_busy,
  output logic                bist_done,
  output logic                bist_pass,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [2:0]          fail_element,
`ifdef MBIST_DIAG_EN
  output logic [7:0]          err_count,
`endif
  input  logic [ADDR_W-1:0]   f_address,
  input  logic [DATA_W/8-1:0] f_byteenable,
  input  logic                f_chipselect,
  input  logic                f_write,
  input  logic [DATA_W-1:0]   f_writedata,
  output logic [DATA_W-1:0]   f_readdata,
  output logic                f_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_E0   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_E5   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [2:0]        elem_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              pend_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [2:0]        fail_elem_r;

  logic [DATA_W-1:0] exp_s;
  logic              down_s;
  logic              last_s;
  logic              cmp_valid_s;
  logic [ADDR_W-1:0] cmp_addr_s;
  logic              mism_s;
  logic              stop_s;
  logic              first_s;
  logic              pass_final_s;
  logic              finish_s;
  logic              start_acc_s;

  // Expected background, traversal direction and compare qualification for the current cycle
  always_comb begin
    exp_s       = ((elem_r == 3'd2) || (elem_r == 3'd4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    down_s      = (elem_r == 3'd3) || (elem_r == 3'd4);
    last_s      = down_s ? (addr_r == ADDR_ZERO) : (addr_r == LAST_ADDR);
    cmp_valid_s = (state_r == S_WR) || (((state_r == S_E5) || (state_r == S_CHK)) && pend_r);
    cmp_addr_s  = (state_r == S_WR) ? addr_r : pend_addr_r;
    mism_s      = cmp_valid_s && (m_readdata != exp_s);
    start_acc_s = (state_r == S_IDLE) && bist_start;
  end

`ifdef MBIST_DIAG_EN
  logic [7:0] err_cnt_r;
  logic [7:0] err_next_s;

  // Saturating miscompare count; a zero count also marks "no failure captured yet"
  always_comb begin
    err_next_s   = (mism_s && (err_cnt_r != 8'd255)) ? (err_cnt_r + 8'd1) : err_cnt_r;
    stop_s       = 1'b0;
    first_s      = (err_cnt_r == 8'd0);
    pass_final_s = (err_next_s == 8'd0);
  end

  // Error counter, cleared on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= 8'd0;
    end else if (start_acc_s) begin
      err_cnt_r <= 8'd0;
    end else begin
      err_cnt_r <= err_next_s;
    end
  end

  assign err_count = err_cnt_r;
`else
  // Stop-on-first-fail: any miscompare ends the run immediately
  always_comb begin
    stop_s       = mism_s;
    first_s      = 1'b1;
    pass_final_s = !mism_s;
  end
`endif

  assign finish_s = stop_s || (state_r == S_CHK);

  // Memory-side mux: functional pass-through when idle, BIST owns every field while busy
  always_comb begin
    if (busy_r) begin
      m_address    = addr_r;
      m_byteenable = {(DATA_W/8){1'b1}};
      m_chipselect = 1'b1;
      m_write      = (state_r == S_E0) || ((state_r == S_WR) && !stop_s);
      m_writedata  = (state_r == S_E0) ? {DATA_W{1'b0}} : ~exp_s;
    end else begin
      m_address    = f_address;
      m_byteenable = f_byteenable;
      m_chipselect = f_chipselect;
      m_write      = f_write;
      m_writedata  = f_writedata;
    end
  end

  assign f_readdata    = m_readdata;
  assign f_waitrequest = busy_r;
  assign bist_busy     = busy_r;
  assign bist_done     = done_r;
  assign bist_pass     = pass_r;
  assign fail_addr     = fail_addr_r;
  assign fail_element  = fail_elem_r;

  // March sequencer: element/address walk and run status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      elem_r      <= 3'd0;
      addr_r      <= ADDR_ZERO;
      pend_addr_r <= ADDR_ZERO;
      pend_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else if (start_acc_s) begin
      state_r <= S_E0;
      elem_r  <= 3'd0;
      addr_r  <= ADDR_ZERO;
      pend_r  <= 1'b0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else if (busy_r && finish_s) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b1;
      pass_r  <= pass_final_s;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_IDLE;
        end
        S_E0: begin
          if (last_s) begin
            state_r <= S_RD;
            elem_r  <= 3'd1;
            addr_r  <= ADDR_ZERO;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
        S_RD: begin
          state_r <= S_WR;
        end
        S_WR: begin
          state_r <= S_RD;
          if (last_s) begin
            if (elem_r == 3'd4) begin
              state_r <= S_E5;
              elem_r  <= 3'd5;
              addr_r  <= ADDR_ZERO;
            end else begin
              elem_r <= elem_r + 3'd1;
              // Elements 3 and 4 walk downwards from the top word
              addr_r <= ((elem_r == 3'd2) || (elem_r == 3'd3)) ? LAST_ADDR : ADDR_ZERO;
            end
          end else begin
            addr_r <= down_s ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
          end
        end
        S_E5: begin
          pend_r      <= 1'b1;
          pend_addr_r <= addr_r;
          if (last_s) begin
            state_r <= S_CHK;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // First-failure capture of address and element
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_addr_r <= ADDR_ZERO;
      fail_elem_r <= 3'd0;
    end else if (start_acc_s) begin
      fail_addr_r <= ADDR_ZERO;
      fail_elem_r <= 3'd0;
    end else if (mism_s && first_s) begin
      fail_addr_r <= cmp_addr_s;
      fail_elem_r <= elem_r;
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a behavioural single-port memory and stuck-at fault injection.
// A reduced DEPTH keeps full March runs short while still exercising DEPTH < 2**ADDR_W.
module tb_mem_bist_ctrl;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 1024;
  localparam int FULL_CYC = 10 * DEPTH + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bist_start;
  logic        bist_busy, bist_done, bist_pass;
  logic [11:0] fail_addr;
  logic [2:0]  fail_element;
  logic [7:0]  err_count;
  logic [11:0] f_address;
  logic [3:0]  f_byteenable;
  logic        f_chipselect, f_write;
  logic [31:0] f_writedata, f_readdata;
  logic        f_waitrequest;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata, m_readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] q_r;
  logic        fault_en = 1'b0;
  logic [11:0] fault_addr = 12'h000;
  int          fault_bit = 0;
  logic        fault_val = 1'b0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bist_start(bist_start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
    .fail_addr(fail_addr), .fail_element(fail_element),
`ifdef MBIST_DIAG_EN
    .err_count(err_count),
`endif
    .f_address(f_address), .f_byteenable(f_byteenable), .f_chipselect(f_chipselect),
    .f_write(f_write), .f_writedata(f_writedata), .f_readdata(f_readdata),
    .f_waitrequest(f_waitrequest),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

`ifndef MBIST_DIAG_EN
  assign err_count = 8'd0;
`endif

  // Single-port memory, byte-masked write, registered read with optional stuck-at bit on q
  always @(posedge clk) begin
    logic [31:0] mask;
    logic [31:0] rd;
    mask = {{8{m_byteenable[3]}}, {8{m_byteenable[2]}}, {8{m_byteenable[1]}}, {8{m_byteenable[0]}}};
    if (m_chipselect) begin
      if (m_write) begin
        mem[m_address] <= (mem[m_address] & ~mask) | (m_writedata & mask);
      end else begin
        rd = mem[m_address];
        if (fault_en && (m_address == fault_addr)) rd[fault_bit] = fault_val;
        q_r <= rd;
      end
    end
  end
  assign m_readdata = q_r;

  task automatic run_bist(input int restart_at, input int req_at, output int cyc,
                          output logic wr_seen, output logic own_seen);
    @(negedge clk) bist_start = 1'b1;
    @(negedge clk) bist_start = 1'b0;
    cyc = 0;
    wr_seen = 1'b0;
    own_seen = 1'b0;
    while (bist_busy && (cyc < 2 * FULL_CYC)) begin
      cyc++;
      if (cyc == req_at) begin
        f_chipselect = 1'b1; f_write = 1'b0; f_address = 12'h010; f_byteenable = 4'h3;
      end
      if (cyc == req_at + 1) begin
        wr_seen  = f_waitrequest;
        own_seen = m_chipselect && (m_byteenable == 4'hF) && (m_address != 12'h010 || m_write);
      end
      if (cyc == restart_at) bist_start = 1'b1;
      if (cyc == restart_at + 1) bist_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; bist_start = 1'b0;
    f_address = 12'h000; f_byteenable = 4'h0; f_chipselect = 1'b0; f_write = 1'b0; f_writedata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (bist_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bist_busy); end
    checks++; if ({bist_done, bist_pass} !== 2'b00) begin errors++; $display("FAIL reset_done_pass got=%b exp=00", {bist_done, bist_pass}); end
    checks++; if ({fail_addr, fail_element} !== 15'h0) begin errors++; $display("FAIL reset_fail_info got=%h/%0d exp=0/0", fail_addr, fail_element); end
    checks++; if (f_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got=%b exp=0", f_waitrequest); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_functional_idle;
    f_chipselect = 1'b1; f_write = 1'b1; f_address = 12'h010; f_byteenable = 4'hF; f_writedata = 32'hDEAD_BEEF;
    #1;
    checks++; if (f_waitrequest !== 1'b0) begin errors++; $display("FAIL idle_waitreq got=%b exp=0", f_waitrequest); end
    checks++; if ({m_address, m_write, m_writedata} !== {12'h010, 1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL idle_passthru got=%h/%b/%h exp=010/1/deadbeef", m_address, m_write, m_writedata); end
    @(negedge clk) f_write = 1'b0;
    @(negedge clk);
    checks++; if (f_readdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_read got=%h exp=deadbeef", f_readdata); end
    f_write = 1'b1; f_byteenable = 4'b0001; f_writedata = 32'h1122_3344;
    @(negedge clk) f_write = 1'b0;
    @(negedge clk);
    checks++; if (f_readdata !== 32'hDEAD_BE44) begin errors++; $display("FAIL idle_byte_write got=%h exp=deadbe44", f_readdata); end
    f_chipselect = 1'b0;
  endtask

  task automatic test_stuck_at1;
    int cyc; logic w, o;
    fault_en = 1'b1; fault_addr = 12'h123; fault_bit = 5; fault_val = 1'b1;
    run_bist(0, 0, cyc, w, o);
`ifdef MBIST_DIAG_EN
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL sa1_busy_cycles got=%0d exp=%0d", cyc, FULL_CYC); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL sa1_err_count got=%0d exp=3", err_count); end
`else
    checks++; if (cyc !== DEPTH + 2 * 12'h123 + 2) begin errors++; $display("FAIL sa1_busy_cycles got=%0d exp=%0d", cyc, DEPTH + 2 * 12'h123 + 2); end
    checks++; if (mem[12'h123] !== 32'h0) begin errors++; $display("FAIL sa1_write_suppressed got=%h exp=0", mem[12'h123]); end
    checks++; if (mem[12'h122] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sa1_prev_written got=%h exp=ffffffff", mem[12'h122]); end
`endif
    checks++; if ({bist_done, bist_pass} !== 2'b10) begin errors++; $display("FAIL sa1_done_pass got=%b exp=10", {bist_done, bist_pass}); end
    checks++; if (fail_addr !== 12'h123) begin errors++; $display("FAIL sa1_fail_addr got=%h exp=123", fail_addr); end
    checks++; if (fail_element !== 3'd1) begin errors++; $display("FAIL sa1_fail_element got=%0d exp=1", fail_element); end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_abort;
    int n;
    @(negedge clk) bist_start = 1'b1;
    @(negedge clk) bist_start = 1'b0;
    checks++; if ({bist_busy, bist_done, bist_pass} !== 3'b100) begin errors++; $display("FAIL restart_clears_status got=%b exp=100", {bist_busy, bist_done, bist_pass}); end
    checks++; if ({fail_addr, fail_element} !== 15'h0) begin errors++; $display("FAIL restart_clears_fail got=%h/%0d exp=0/0", fail_addr, fail_element); end
    for (n = 1; n < 5000 && bist_busy; n++) @(negedge clk);
    checks++; if (bist_busy !== 1'b1) begin errors++; $display("FAIL abort_still_busy got=%b exp=1", bist_busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bist_busy, bist_done, bist_pass, f_waitrequest} !== 4'b0000) begin
      errors++; $display("FAIL abort_async_clear got=%b exp=0000", {bist_busy, bist_done, bist_pass, f_waitrequest}); end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_pass;
    int cyc, nz; logic w, o;
    run_bist(50, 10, cyc, w, o);
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL pass_busy_cycles got=%0d exp=%0d", cyc, FULL_CYC); end
    checks++; if ({bist_done, bist_pass} !== 2'b11) begin errors++; $display("FAIL pass_done_pass got=%b exp=11", {bist_done, bist_pass}); end
    checks++; if ({fail_addr, fail_element} !== 15'h0) begin errors++; $display("FAIL pass_fail_info got=%h/%0d exp=0/0", fail_addr, fail_element); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL busy_waitreq got=%b exp=1", w); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL busy_bist_owns_port got=%b exp=1", o); end
    checks++; if ({f_waitrequest, m_address, m_chipselect, m_write, m_byteenable} !== {1'b0, 12'h010, 1'b1, 1'b0, 4'h3}) begin
      errors++; $display("FAIL held_req_serviced got=%b/%h/%b/%b/%h exp=0/010/1/0/3",
                         f_waitrequest, m_address, m_chipselect, m_write, m_byteenable); end
    @(negedge clk);
    checks++; if (f_readdata !== 32'h0) begin errors++; $display("FAIL held_req_data got=%h exp=0", f_readdata); end
    f_chipselect = 1'b0;
    nz = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 32'h0) nz++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL pass_mem_zero got=%0d nonzero words exp=0", nz); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL pass_err_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_stuck_at0;
    int cyc; logic w, o;
    fault_en = 1'b1; fault_addr = 12'(DEPTH - 1); fault_bit = 0; fault_val = 1'b0;
    run_bist(0, 0, cyc, w, o);
`ifdef MBIST_DIAG_EN
    checks++; if (cyc !== FULL_CYC) begin errors++; $display("FAIL sa0_busy_cycles got=%0d exp=%0d", cyc, FULL_CYC); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL sa0_err_count got=%0d exp=2", err_count); end
`else
    checks++; if (cyc !== 5 * DEPTH) begin errors++; $display("FAIL sa0_busy_cycles got=%0d exp=%0d", cyc, 5 * DEPTH); end
`endif
    checks++; if ({bist_done, bist_pass} !== 2'b10) begin errors++; $display("FAIL sa0_done_pass got=%b exp=10", {bist_done, bist_pass}); end
    checks++; if (fail_addr !== 12'(DEPTH - 1)) begin errors++; $display("FAIL sa0_fail_addr got=%h exp=%h", fail_addr, 12'(DEPTH - 1)); end
    checks++; if (fail_element !== 3'd2) begin errors++; $display("FAIL sa0_fail_element got=%0d exp=2", fail_element); end
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_functional_idle();
    test_stuck_at1();
    test_reset_abort();
    test_full_pass();
    test_stuck_at0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
